bit_serializer: RTL
===================

# bit_serializer

Parallel-to-serial front end for the serial pattern-detector path. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a single-bit stream, which the downstream bit-level detector samples every cycle. A one-word holding buffer lets back-to-back words stream with no idle gap. Idle cycles drive a fixed fill bit.

## Interface
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0: value driven on sout when no word is shifting.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- din  in  WIDTH  parallel word.
- din_valid  in  1  din holds a word.
- din_ready  out  1  block can accept a word this cycle.
- sout  out  1  serial data bit, registered.
- sout_valid  out  1  sout carries a word bit, registered.
- busy  out  1  shifter active or hold buffer full.
- gap  out  1  one-cycle pulse: stream ended with no pending word.

## Operation
- Storage:
  - shift register (WIDTH);
  - hold register (WIDTH) plus hold_full flag;
  - bit counter cnt, width $clog2(WIDTH), counts 0..WIDTH-1;
  - state: IDLE or SHIFT.
- Accept when din_valid && din_ready. din_ready = !hold_full, driven from the registered flag with no combinational path from din_valid.
- IDLE + accept: load din into shifter, cnt <= 0, go to SHIFT.
- SHIFT, each cycle: present the current bit, cnt++, shift the register (direction per MSB_FIRST).
- SHIFT + accept, not last bit: word goes to hold, hold_full <= 1.
- Last bit (cnt == WIDTH-1):
  - If hold_full: transfer hold to shifter, hold_full <= 0, cnt <= 0, stay in SHIFT.
  - Else if accept in the same cycle: load din directly into shifter, stay in SHIFT, no gap.
  - Else: go to IDLE, gap <= 1 for one cycle.
- Last bit with hold_full: din_ready is 0 that cycle, so no third word can arrive.
- In IDLE: sout = IDLE_BIT, sout_valid = 0.
- busy = (state == SHIFT) || hold_full.

## Timing
- Reset values:
  - sout = IDLE_BIT, sout_valid = 0, din_ready = 1, busy = 0, gap = 0;
  - state IDLE, cnt 0, hold_full 0, shifter and hold cleared.
- Latency: the first bit of an accepted word appears on sout/sout_valid in the cycle after the accepting edge.
- Each word occupies exactly WIDTH consecutive sout_valid cycles.
- Back-to-back: if the next word is accepted before or on the last-bit cycle, the sout_valid run is continuous across words.
- gap asserts in the cycle after the final bit of a run, i.e. the first cycle with sout_valid = 0.
- din_ready falls the cycle after the hold buffer fills. It rises the cycle after the hold buffer transfers to the shifter.
- Reset mid-word: all state clears immediately and asynchronously. A partial word is dropped and never resumed. The held word is discarded.
- din is ignored when din_ready = 0, even if din_valid = 1.

## Structure
- Shared package:
  - state enum (SER_IDLE, SER_SHIFT);
  - default WIDTH constant;
  - IDLE_BIT default.
- The downstream detector already uses a 2-bit state encoding, so this block's enum must keep its own distinct name.
- No sub-module: the holding buffer and shifter are one register pair each and stay inline in a single module.

## Test plan
- After reset: sout = 0, sout_valid = 0, din_ready = 1, busy = 0, gap = 0, held for 5 cycles with din_valid = 0.
- WIDTH = 8, MSB_FIRST = 1, single word 0xA5:
  - sout = 1,0,1,0,0,1,0,1 on cycles 1..8 after accept, with sout_valid high;
  - gap pulses on cycle 9;
  - busy low from cycle 9.
- Words 0xF0 then 0x0F, second offered on cycle 2:
  - 16 contiguous sout_valid cycles, sout = 1111000000001111;
  - din_ready low cycles 3..8;
  - no gap until cycle 17.
- Word 0x81 with MSB_FIRST = 0: sout = 1,0,0,0,0,0,0,1. Then a new word 0x3C is presented exactly on the last-bit cycle with the hold buffer empty: sout continues with no gap as 0,0,1,1,1,1,0,0.
- Third word offered while the hold buffer is full: din_ready = 0 and the word is not consumed. It is accepted only after din_ready returns to 1, and appears once, in order.
- rst asserted on bit 4 of 0xC3 with a word held:
  - sout = IDLE_BIT and sout_valid = 0 immediately;
  - after release, din_ready = 1 and no residual bits are emitted.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the parallel-to-serial front end.
//   ser_state_e       : shifter state (own name, distinct from the detector's enum)
//   SER_WIDTH_DEF     : default word width
//   SER_IDLE_BIT_DEF  : default fill bit driven while no word is shifting
package bit_serializer_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  localparam int   SER_WIDTH_DEF    = 8;
  localparam logic SER_IDLE_BIT_DEF = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: accepts WIDTH-bit words on a valid/ready handshake and emits
// them one bit per clock. A one-word hold buffer lets consecutive words stream
// with no idle cycle between them.
//   clk, rst    : clock, asynchronous active-high reset
//   din         : parallel word, taken when din_valid && din_ready
//   din_ready   : low only while the hold buffer is full (registered flag)
//   sout        : serial bit (registered), IDLE_BIT when not shifting
//   sout_valid  : sout carries a word bit (registered)
//   busy        : shifting or hold buffer occupied
//   gap         : one-cycle pulse on the first idle cycle after a run
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH     = SER_WIDTH_DEF,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = SER_IDLE_BIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             gap
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_e       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg, sh_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic             hold_full, hf_nxt;
  logic             sout_nxt, sv_nxt, gap_nxt;
  logic             accept, last;

  // Bit that goes out first for a freshly loaded word.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign din_ready = !hold_full;
  assign accept    = din_valid && din_ready;
  assign last      = (cnt == LAST);
  assign busy      = (state == SER_SHIFT) || hold_full;

  // sout is registered, so the bit for the coming cycle is chosen here: on a
  // load it is the word's first bit, otherwise the next bit of the current
  // shifter contents. cnt is the index of the bit currently on sout.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_nxt    = shreg;
    hold_nxt  = hold;
    hf_nxt    = hold_full;
    sout_nxt  = IDLE_BIT;
    sv_nxt    = 1'b0;
    gap_nxt   = 1'b0;
    case (state)
      SER_IDLE: begin
        if (accept) begin
          state_nxt = SER_SHIFT;
          sh_nxt    = din;
          cnt_nxt   = '0;
          sout_nxt  = first_bit(din);
          sv_nxt    = 1'b1;
        end
      end
      SER_SHIFT: begin
        if (!last) begin
          cnt_nxt  = cnt + CW'(1);
          sh_nxt   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
          sout_nxt = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
          sv_nxt   = 1'b1;
          if (accept) begin
            hold_nxt = din;
            hf_nxt   = 1'b1;
          end
        end else if (hold_full) begin
          // din_ready is low here, so no new word competes with the transfer.
          sh_nxt   = hold;
          hold_nxt = '0;
          hf_nxt   = 1'b0;
          cnt_nxt  = '0;
          sout_nxt = first_bit(hold);
          sv_nxt   = 1'b1;
        end else if (accept) begin
          // Word arriving on the last bit bypasses the hold buffer.
          sh_nxt   = din;
          cnt_nxt  = '0;
          sout_nxt = first_bit(din);
          sv_nxt   = 1'b1;
        end else begin
          state_nxt = SER_IDLE;
          cnt_nxt   = '0;
          gap_nxt   = 1'b1;
        end
      end
      default: state_nxt = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SER_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      sout       <= IDLE_BIT;
      sout_valid <= 1'b0;
      gap        <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shreg      <= sh_nxt;
      hold       <= hold_nxt;
      hold_full  <= hf_nxt;
      sout       <= sout_nxt;
      sout_valid <= sv_nxt;
      gap        <= gap_nxt;
    end
  end

endmodule
